// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_defs (package)
//  Purpose  : Shared definitions for the execute-stage ALU: ALU control
//             codes, FSM state encoding, shift-kind encoding and the
//             is_shift() decode helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_defs;

  // ALU control codes as produced by the upstream ALU control decoder
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;

  // FSM state encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Kind of serial shift currently in flight
  typedef enum logic [1:0] {
    SK_SLL = 2'd0,
    SK_SRL = 2'd1,
    SK_SRA = 2'd2
  } shift_kind_t;

  function automatic logic is_shift(input logic [4:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

  function automatic shift_kind_t shift_kind(input logic [4:0] ctl);
    shift_kind_t k;
    case (ctl)
      ALU_SRL: k = SK_SRL;
      ALU_SRA: k = SK_SRA;
      default: k = SK_SLL;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_comb_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_comb_core
//  Purpose  : Single-cycle combinational ALU: AND/OR/ADD/SUB/SLT/NOR/XOR
//             with signed-overflow detection. Unlisted codes act as ADD.
//  Ports    : ALUCtl   in  5      operation code
//             Sign     in  1      signed SLT compare / overflow enable
//             A, B     in  WIDTH  operands
//             Result   out WIDTH  combinational result
//             Overflow out 1      signed overflow (ADD/SUB only)
//  Revision : 1.0  initial release
// ============================================================================
module alu_comb_core
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       ALUCtl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum  = A + B;
  assign diff = A - B;
  assign lt   = Sign ? ($signed(A) < $signed(B)) : (A < B);

  // Signed overflow: result sign disagrees with A when the operation could
  // not legitimately have changed it (like signs for ADD, unlike for SUB).
  assign add_ovf = Sign & (A[MSB] == B[MSB]) & (sum[MSB]  != A[MSB]);
  assign sub_ovf = Sign & (A[MSB] != B[MSB]) & (diff[MSB] != A[MSB]);

  always_comb begin
    Result   = sum;
    Overflow = 1'b0;
    case (ALUCtl)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SUB: begin
        Result   = diff;
        Overflow = sub_ovf;
      end
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR: Result = ~(A | B);
      ALU_XOR: Result = A ^ B;
      default: begin
        Result   = sum;
        Overflow = add_ovf;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute-stage ALU of the multicycle MIPS datapath. Logical and
//             arithmetic ops complete in one cycle; shifts use a serial
//             1-bit/cycle shifter. Valid/ready on both sides, with Result,
//             Zero and Overflow registered and held until accepted.
//  Ports    : clk, reset            clock, sync active-high reset
//             in_valid / in_ready   operation handshake (ready only in IDLE)
//             ALUCtl, Sign          control code, signed-mode flag
//             A, B, Shamt           operands and shift amount
//             flush                 abort in-flight operation
//             out_valid / out_ready result handshake
//             Result, Zero, Overflow registered outputs
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit
  import alu_defs::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [SHW-1:0]   cnt_q,    cnt_d;
  shift_kind_t      kind_q,   kind_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             accept;
  logic             op_is_shift;
  logic             load_shift;
  logic             last_step;
  logic [WIDTH-1:0] imm_result;
  logic             imm_ovf;
  logic [WIDTH-1:0] shift_next;

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .ALUCtl   (ALUCtl),
    .Sign     (Sign),
    .A        (A),
    .B        (B),
    .Result   (core_result),
    .Overflow (core_ovf)
  );

  assign op_is_shift = is_shift(ALUCtl);
  assign accept      = (state_q == ST_IDLE) & in_valid & ~flush;
  // A zero-distance shift is just B and completes like a one-cycle op
  assign load_shift  = accept & op_is_shift & (Shamt != '0);
  assign last_step   = (cnt_q == SHW'(1));

  assign imm_result  = op_is_shift ? B : core_result;
  assign imm_ovf     = op_is_shift ? 1'b0 : core_ovf;

  // One-bit step of the serial shifter
  always_comb begin
    shift_next = shreg_q;
    case (kind_q)
      SK_SLL:  shift_next = {shreg_q[WIDTH-2:0], 1'b0};
      SK_SRL:  shift_next = {1'b0, shreg_q[WIDTH-1:1]};
      default: shift_next = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register (with datapath registers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      kind_q   <= SK_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = load_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

  // --------------------------------------------------------------------------
  // Datapath next values. Result/Zero/Overflow only change when a final
  // value is produced, so they hold through DONE, flush and idle cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;

    if (load_shift) begin
      shreg_d = B;
      cnt_d   = Shamt;
      kind_d  = shift_kind(ALUCtl);
    end else if (accept) begin
      result_d = imm_result;
      zero_d   = (imm_result == '0);
      ovf_d    = imm_ovf;
    end

    if ((state_q == ST_SHIFT) && !flush) begin
      shreg_d = shift_next;
      cnt_d   = cnt_q - SHW'(1);
      if (last_step) begin
        result_d = shift_next;
        zero_d   = (shift_next == '0);
        ovf_d    = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit: directed vectors with
//             literal expectations plus a cycle-by-cycle reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    ALUCtl;
  logic          Sign;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [4:0]    Shamt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          Zero;
  logic          Overflow;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUCtl    (ALUCtl),
    .Sign      (Sign),
    .A         (A),
    .B         (B),
    .Shamt     (Shamt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference arithmetic, straight from the operation definitions
  // --------------------------------------------------------------------------
  function automatic void ref_alu(input logic [4:0] ctl, input logic sg,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh,
                                  output logic [31:0] r, output logic ov);
    longint sa, sb, t;
    longint maxp, minn;
    logic   lt;
    maxp = 64'sd2147483647;
    minn = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    case (ctl)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00110: begin
        r  = a - b;
        t  = sa - sb;
        ov = sg && (t > maxp || t < minn);
      end
      5'b00111: begin
        lt = sg ? (sa < sb) : (a < b);
        r  = {31'b0, lt};
      end
      5'b01100: r = ~(a | b);
      5'b01101: r = a ^ b;
      5'b10000: r = b << sh;
      5'b11000: r = b >> sh;
      5'b11001: r = $unsigned($signed(b) >>> sh);
      default: begin
        r  = a + b;
        t  = sa + sb;
        ov = sg && (t > maxp || t < minn);
      end
    endcase
  endfunction

  function automatic logic ref_is_shift(input logic [4:0] ctl);
    return (ctl == 5'b10000) || (ctl == 5'b11000) || (ctl == 5'b11001);
  endfunction

  // --------------------------------------------------------------------------
  // Cycle model: valid after (Shamt+1) edges for real shifts, 1 edge otherwise
  // --------------------------------------------------------------------------
  logic        m_init = 1'b0;
  logic        m_valid, m_busy;
  int          m_wait;
  logic [31:0] m_res, p_res;
  logic        m_zero, m_ovf, p_ovf;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        o;
    if (reset) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_wait  <= 0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_valid) begin
      if (flush || out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy <= 1'b0;
      end else begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_res   <= p_res;
          m_zero  <= (p_res == 32'd0);
          m_ovf   <= p_ovf;
        end
      end
    end else if (in_valid && !flush) begin
      ref_alu(ALUCtl, Sign, A, B, Shamt, r, o);
      if (ref_is_shift(ALUCtl) && Shamt != 5'd0) begin
        m_busy <= 1'b1;
        m_wait <= int'(Shamt);
        p_res  <= r;
        p_ovf  <= o;
      end else begin
        m_valid <= 1'b1;
        m_res   <= r;
        m_zero  <= (r == 32'd0);
        m_ovf   <= o;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init && !reset) begin
      chk1 ("cyc out_valid", out_valid, m_valid);
      chk1 ("cyc in_ready",  in_ready,  !m_valid && !m_busy);
      chk32("cyc Result",    Result,    m_res);
      chk1 ("cyc Zero",      Zero,      m_zero);
      chk1 ("cyc Overflow",  Overflow,  m_ovf);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] ctl, input logic sg,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    ALUCtl   = ctl;
    Sign     = sg;
    A        = a;
    B        = b;
    Shamt    = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble operands after accept; they must not matter any more
    A        = ~a;
    B        = ~b;
    ALUCtl   = 5'b00110;
    Shamt    = ~sh;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] ctl, input logic sg,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic ez, input logic eo,
                        input int elat, input int hold);
    int lat;
    issue(ctl, sg, a, b, sh);
    wait_valid(lat);
    chk32({name, " latency"}, 32'(lat), 32'(elat));
    chk1 ({name, " out_valid"}, out_valid, 1'b1);
    chk32({name, " Result"}, Result, er);
    chk1 ({name, " Zero"}, Zero, ez);
    chk1 ({name, " Overflow"}, Overflow, eo);
    repeat (hold) tick();
    chk32({name, " held Result"}, Result, er);
    chk1 ({name, " held Overflow"}, Overflow, eo);
    chk1 ({name, " held in_ready"}, in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1({name, " released out_valid"}, out_valid, 1'b0);
    chk1({name, " released in_ready"}, in_ready, 1'b1);
  endtask

  task automatic chk_cleared(input string name);
    chk1 ({name, " out_valid"}, out_valid, 1'b0);
    chk1 ({name, " in_ready"},  in_ready,  1'b1);
    chk32({name, " Result"},    Result,    32'd0);
    chk1 ({name, " Zero"},      Zero,      1'b0);
    chk1 ({name, " Overflow"},  Overflow,  1'b0);
  endtask

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ALUCtl = 5'b0; Sign = 1'b0; A = '0; B = '0; Shamt = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk_cleared("reset");

    // Arithmetic / overflow, with 3 cycles of backpressure on the first op
    run_op("add ovf",  5'b00010, 1'b1, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b1, 1, 3);
    run_op("add uns",  5'b00010, 1'b0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b0, 1, 0);
    run_op("slt sgn",  5'b00111, 1'b1, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1, 0);
    run_op("slt uns",  5'b00111, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1, 0);
    run_op("sub zero", 5'b00110, 1'b1, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b0, 1, 1);
    run_op("and",      5'b00000, 1'b0, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000F000, 1'b0, 1'b0, 1, 0);
    run_op("or",       5'b00001, 1'b0, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000FFF0, 1'b0, 1'b0, 1, 0);
    run_op("nor",      5'b01100, 1'b0, 32'hF0F0, 32'hFF00, 5'd0, 32'hFFFF000F, 1'b0, 1'b0, 1, 0);
    run_op("xor",      5'b01101, 1'b0, 32'hF0F0, 32'hFF00, 5'd0, 32'h00000FF0, 1'b0, 1'b0, 1, 0);

    // Serial shifter
    run_op("sra 4",    5'b11001, 1'b0, 32'h0, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 5, 2);
    run_op("srl 4",    5'b11000, 1'b0, 32'h0, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 5, 0);
    run_op("sll 31",   5'b10000, 1'b0, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 32, 0);
    run_op("sll 0",    5'b10000, 1'b1, 32'h7FFFFFFF, 32'h0000ABCD, 5'd0, 32'h0000ABCD, 1'b0, 1'b0, 1, 0);

    // flush in IDLE blocks acceptance
    ALUCtl = 5'b00010; A = 32'd9; B = 32'd9; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk1("idle flush in_ready", in_ready, 1'b1);
    tick();
    chk1("idle flush out_valid", out_valid, 1'b0);

    // flush on the 3rd SHIFT cycle of SRL 10
    issue(5'b11000, 1'b0, 32'h0, 32'hFFFF0000, 5'd10);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1 ("shift flush in_ready",  in_ready,  1'b1);
    chk1 ("shift flush out_valid", out_valid, 1'b0);
    chk32("shift flush Result",    Result,    32'h0000ABCD);
    repeat (12) tick();
    chk1 ("shift flush later out_valid", out_valid, 1'b0);
    run_op("add 2+3", 5'b00010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1, 0);

    // reset in SHIFT
    issue(5'b10000, 1'b0, 32'h0, 32'h1, 5'd31);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("reset in shift");

    // reset in DONE
    issue(5'b00010, 1'b1, 32'h7FFFFFFF, 32'h1, 5'd0);
    wait_valid(lat);
    chk1("pre-reset Overflow", Overflow, 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("reset in done");

    // Unlisted code behaves as ADD
    run_op("unlisted", 5'b01111, 1'b0, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1'b0, 1, 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
